// File: rtl/mc_arb_pkg.sv
// Shared definitions for the external memory-bus ownership arbiter:
// state encoding and counter width.
package mc_arb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_OWN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_TURN_X = 3'd2,
    ST_GRANT  = 3'd3,
    ST_REVOKE = 3'd4,
    ST_TURN_I = 3'd5
  } arb_state_e;

endpackage

// File: rtl/mc_bus_arb.sv
// External bus ownership arbiter: runs the br/bg handshake, drains the sequencer,
// inserts turnaround cycles and bounds external hold time while internal work waits.
module mc_bus_arb
  import mc_arb_pkg::*;
#(
  parameter int TURN     = 1,
  parameter int MAX_HOLD = 64,
  parameter int MIN_OWN  = 8
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       mc_br_r,
  input  logic       mc_req,
  input  logic       rfr_req,
  input  logic       mc_idle,
  output logic       mc_bg_d,
  output logic       mc_hold,
  output logic       mc_own,
  output logic [2:0] arb_st
);

  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] OWN_LD  = CNT_W'(MIN_OWN);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_dec;

  // One shared down-counter; it parks at zero instead of wrapping.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_OWN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OWN: begin
        cnt_d = cnt_dec;
        if (mc_br_r && ((cnt_q == '0) || !mc_req)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A dropped request aborts the handover and keeps the MIN_OWN count.
        if (!mc_br_r) begin
          state_d = ST_OWN;
        end else if (mc_idle) begin
          state_d = ST_TURN_X;
          cnt_d   = TURN_LD;
        end
      end
      ST_TURN_X: begin
        if (cnt_q == '0) begin
          state_d = ST_GRANT;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      ST_GRANT: begin
        // Release beats refresh and hold expiry so the turnaround is not doubled.
        if (!mc_br_r) begin
          state_d = ST_TURN_I;
          cnt_d   = TURN_LD;
        end else if (rfr_req) begin
          state_d = ST_REVOKE;
        end else if (mc_req) begin
          if (cnt_q == '0) state_d = ST_REVOKE;
          else             cnt_d   = cnt_dec;
        end
      end
      ST_REVOKE: begin
        if (!mc_br_r) begin
          state_d = ST_TURN_I;
          cnt_d   = TURN_LD;
        end
      end
      ST_TURN_I: begin
        if (cnt_q == '0) begin
          state_d = ST_OWN;
          cnt_d   = OWN_LD;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = ST_OWN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    mc_bg_d = 1'b0;
    mc_hold = 1'b1;
    mc_own  = 1'b0;
    unique case (state_q)
      ST_OWN:    begin mc_hold = 1'b0; mc_own = 1'b1; end
      ST_DRAIN:  mc_own  = 1'b1;
      ST_GRANT:  mc_bg_d = 1'b1;
      ST_TURN_X, ST_REVOKE, ST_TURN_I: mc_own = 1'b0;
      default:   begin mc_hold = 1'b0; mc_own = 1'b1; end
    endcase
  end

  assign arb_st = state_q;

endmodule

// File: tb/tb_mc_bus_arb.sv
// Bench for mc_bus_arb with TURN=1, MAX_HOLD=4, MIN_OWN=8: vector table plus
// hand sequences for long drain and asynchronous reset.
module tb_mc_bus_arb;

  localparam logic [2:0] S_OWN    = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_TURN_X = 3'd2;
  localparam logic [2:0] S_GRANT  = 3'd3;
  localparam logic [2:0] S_REVOKE = 3'd4;
  localparam logic [2:0] S_TURN_I = 3'd5;

  logic       clk = 1'b0;
  logic       rst_;
  logic       mc_br_r, mc_req, rfr_req, mc_idle;
  logic       mc_bg_d, mc_hold, mc_own;
  logic [2:0] arb_st;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       br;
    logic       req;
    logic       rfr;
    logic       idle;
    logic [2:0] st;
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] exp_q[$];

  mc_bus_arb #(.TURN(1), .MAX_HOLD(4), .MIN_OWN(8)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .mc_br_r (mc_br_r),
    .mc_req  (mc_req),
    .rfr_req (rfr_req),
    .mc_idle (mc_idle),
    .mc_bg_d (mc_bg_d),
    .mc_hold (mc_hold),
    .mc_own  (mc_own),
    .arb_st  (arb_st)
  );

  always #5 clk = ~clk;

  // {bg, hold, own} required in each state
  function automatic logic [2:0] outs_of(input logic [2:0] st);
    case (st)
      S_OWN:    return 3'b001;
      S_DRAIN:  return 3'b011;
      S_TURN_X: return 3'b010;
      S_GRANT:  return 3'b110;
      S_REVOKE: return 3'b010;
      S_TURN_I: return 3'b010;
      default:  return 3'b000;
    endcase
  endfunction

  task automatic add(input logic br, input logic req, input logic rfr,
                     input logic idle, input logic [2:0] st);
    vec_t v;
    v.br = br; v.req = req; v.rfr = rfr; v.idle = idle; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic check_out(input string tag);
    logic [2:0] es;
    logic [2:0] eo;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, arb_st=%0d", tag, arb_st);
      return;
    end
    es = exp_q.pop_front();
    eo = outs_of(es);
    if (arb_st !== es) begin
      errors++;
      $display("FAIL %s: arb_st got %0d want %0d", tag, arb_st, es);
    end
    checks++;
    if ({mc_bg_d, mc_hold, mc_own} !== eo) begin
      errors++;
      $display("FAIL %s: bg/hold/own got %b%b%b want %b", tag, mc_bg_d, mc_hold, mc_own, eo);
    end
  endtask

  task automatic apply(input logic br, input logic req, input logic rfr,
                       input logic idle, input logic [2:0] st, input string tag);
    mc_br_r = br; mc_req = req; rfr_req = rfr; mc_idle = idle;
    exp_q.push_back(st);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  // Ownership and grant must never overlap.
  always @(negedge clk) begin
    checks++;
    if (mc_own && mc_bg_d) begin
      errors++;
      $display("FAIL own_vs_bg: own=%b bg=%b want not both 1", mc_own, mc_bg_d);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, want bench done", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1'b0;
    mc_br_r = 1'b0; mc_req = 1'b0; rfr_req = 1'b0; mc_idle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(S_OWN);
    check_out("reset");
    rst_ = 1'b1;

    // basic grant then normal release
    add(1, 0, 0, 1, S_DRAIN);
    add(1, 0, 0, 1, S_TURN_X);
    add(1, 0, 0, 1, S_GRANT);
    add(1, 0, 0, 1, S_GRANT);
    add(0, 0, 0, 1, S_TURN_I);
    add(0, 0, 0, 1, S_OWN);
    // drain waits for idle
    add(1, 0, 0, 0, S_DRAIN);
    add(1, 0, 0, 0, S_DRAIN);
    add(1, 0, 0, 0, S_DRAIN);
    add(1, 0, 0, 0, S_DRAIN);
    add(1, 0, 0, 1, S_TURN_X);
    add(1, 0, 0, 1, S_GRANT);
    // hold expiry with internal work pending: 4 grant cycles total
    add(1, 1, 0, 1, S_GRANT);
    add(1, 1, 0, 1, S_GRANT);
    add(1, 1, 0, 1, S_GRANT);
    add(1, 1, 0, 1, S_REVOKE);
    add(1, 1, 0, 1, S_REVOKE);
    add(0, 1, 0, 1, S_TURN_I);
    add(0, 1, 0, 1, S_OWN);
    // minimum ownership: request ignored for 8 cycles
    for (int k = 0; k < 8; k++) add(1, 1, 0, 0, S_OWN);
    add(1, 1, 0, 0, S_DRAIN);
    // abort during drain
    add(0, 1, 0, 0, S_OWN);
    add(0, 1, 0, 0, S_OWN);
    // refresh preempt
    add(1, 0, 0, 1, S_DRAIN);
    add(1, 0, 0, 1, S_TURN_X);
    add(1, 0, 0, 1, S_GRANT);
    add(1, 0, 1, 1, S_REVOKE);
    add(1, 0, 0, 1, S_REVOKE);
    add(0, 0, 0, 1, S_TURN_I);
    add(0, 0, 0, 1, S_OWN);
    // release coincident with refresh takes the release path
    add(1, 0, 0, 1, S_DRAIN);
    add(1, 0, 0, 1, S_TURN_X);
    add(1, 0, 0, 1, S_GRANT);
    add(0, 0, 1, 1, S_TURN_I);
    add(0, 0, 0, 1, S_OWN);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].br, tbl[i].req, tbl[i].rfr, tbl[i].idle, tbl[i].st,
            $sformatf("vec%0d", i));

    // asynchronous reset while granted
    apply(1, 0, 0, 1, S_DRAIN,  "ar_drain");
    apply(1, 0, 0, 1, S_TURN_X, "ar_turnx");
    apply(1, 0, 0, 1, S_GRANT,  "ar_grant");
    #2;
    rst_ = 1'b0;
    #1;
    checks++;
    if ({arb_st, mc_bg_d, mc_hold, mc_own} !== {S_OWN, 3'b001}) begin
      errors++;
      $display("FAIL async_rst: st=%0d bg/hold/own=%b%b%b want st=0 001",
               arb_st, mc_bg_d, mc_hold, mc_own);
    end
    exp_q.push_back(S_OWN);
    @(posedge clk);
    #1;
    check_out("rst_held");
    rst_ = 1'b1;

    // counter cleared by reset: request honoured at once even with mc_req=1,
    // then a long drain of 10 cycles before idle
    apply(1, 1, 0, 0, S_DRAIN, "ld_enter");
    for (int k = 0; k < 9; k++) apply(1, 1, 0, 0, S_DRAIN, $sformatf("ld_wait%0d", k));
    apply(1, 1, 0, 1, S_TURN_X, "ld_turnx");
    apply(1, 1, 0, 1, S_GRANT,  "ld_grant");
    apply(0, 1, 0, 1, S_TURN_I, "ld_rel");
    apply(0, 1, 0, 1, S_OWN,    "ld_own");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
